// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two valid/ready requesters.
// One operation in flight: operands are registered into the ALU, the result is registered back out.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_ctrl0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_ctrl1,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             gnt;
  logic             sel;
  logic             take;
  logic             rsp_take;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_ctrl;

  function automatic logic is_legal(input logic [2:0] code);
    case (code)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req_valid0 && req_valid1) sel = ~last_grant;
    else if (req_valid1)          sel = 1'b1;
    req_ready0 = rst_n && (state == IDLE) && req_valid0 && !sel;
    req_ready1 = rst_n && (state == IDLE) && req_valid1 && sel;
    take       = req_ready0 || req_ready1;
    sel_a      = sel ? req_a1 : req_a0;
    sel_b      = sel ? req_b1 : req_b0;
    sel_ctrl   = sel ? req_ctrl1 : req_ctrl0;
    rsp_take   = gnt ? (rsp_valid1 && rsp_ready1) : (rsp_valid0 && rsp_ready0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            gnt <= sel;
            // Illegal opcodes bypass the ALU so it only ever sees legal controls.
            if (is_legal(sel_ctrl)) begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_ctrl <= sel_ctrl;
              state    <= EXEC;
            end else begin
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid0 <= !sel;
              rsp_valid1 <= sel;
              state      <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
          rsp_valid0 <= !gnt;
          rsp_valid1 <= gnt;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            last_grant <= gnt;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model of the arbitration rules plus a behavioural ALU,
// checked every cycle, with directed scenarios and a randomized two-requester phase.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } op_t;

  typedef struct packed {
    logic        n;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } rec_t;

  logic        clk, rst_n;
  logic        req_valid0, req_ready0, req_valid1, req_ready1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_ctrl0, req_ctrl1;
  logic        rsp_valid0, rsp_ready0, rsp_valid1, rsp_ready1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;

  op_t  q0[$];
  op_t  q1[$];
  rec_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int rdy_mode = 0;
  int bp_cnt = 0;
  bit gaps = 0;
  logic busy = 1'b0, model_last = 1'b1, cur_n = 1'b0, hs0 = 1'b0, hs1 = 1'b0;
  logic e0, e1, in_resp;
  logic [31:0] exp_a, exp_b, exp_res;
  logic [2:0]  exp_ctrl;
  logic        exp_zero, exp_err;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_a0(req_a0), .req_b0(req_b0), .req_ctrl0(req_ctrl0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_a1(req_a1), .req_b1(req_b1), .req_ctrl1(req_ctrl1),
    .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0), .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic legal(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd5);
  endfunction

  function automatic logic [31:0] rnd();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 2));
    return $urandom;
  endfunction

  // Behavioural ALU attached to the arbiter's ALU port.
  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input int idx, input logic n, input logic [31:0] res,
                         input logic zero, input logic err);
    if (idx < done_q.size()) begin
      chk1({nm, "_grant"}, done_q[idx].n, n);
      chk32({nm, "_result"}, done_q[idx].res, res);
      chk1({nm, "_zero"}, done_q[idx].zero, zero);
      chk1({nm, "_err"}, done_q[idx].err, err);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_missing: got %0d responses expected more than %0d", nm, done_q.size(), idx);
    end
  endtask

  task automatic add_op(input logic n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    op_t op;
    op.a = a;
    op.b = b;
    op.c = c;
    if (n) q1.push_back(op);
    else   q0.push_back(op);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input string nm, input int limit);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req_valid0 || req_valid1 || busy) && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk1({nm, "_drain_in_time"}, n < limit, 1'b1);
    #2;
  endtask

  // Requester and response-consumer driver.
  initial begin
    op_t op;
    forever begin
      @(posedge clk);
      #1;
      if (hs0) req_valid0 = 1'b0;
      if (hs1) req_valid1 = 1'b0;
      if (!req_valid0 && q0.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
        op = q0.pop_front();
        req_a0 = op.a; req_b0 = op.b; req_ctrl0 = op.c; req_valid0 = 1'b1;
      end
      if (!req_valid1 && q1.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
        op = q1.pop_front();
        req_a1 = op.a; req_b1 = op.b; req_ctrl1 = op.c; req_valid1 = 1'b1;
      end
      case (rdy_mode)
        1: begin
          rsp_ready0 = 1'($urandom_range(0, 1));
          rsp_ready1 = 1'($urandom_range(0, 1));
        end
        2: begin
          rsp_ready1 = 1'b1;
          if (rsp_valid0) bp_cnt++;
          else            bp_cnt = 0;
          rsp_ready0 = (bp_cnt > 5);
        end
        default: begin
          rsp_ready0 = 1'b1;
          rsp_ready1 = 1'b1;
        end
      endcase
    end
  end

  // Reference model and per-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; model_last = 1'b1; hs0 = 1'b0; hs1 = 1'b0;
        chk32("reset_ctl", {26'd0, req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero, rsp_err}, 32'd0);
        chk32("reset_rsp_result", rsp_result, 32'd0);
        chk32("reset_alu_a", alu_a, 32'd0);
        chk32("reset_alu_b", alu_b, 32'd0);
        chk32("reset_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      end else begin
        cyc++;
        hs0 = req_valid0 && req_ready0;
        hs1 = req_valid1 && req_ready1;
        e0 = !busy && req_valid0 && (!req_valid1 || model_last);
        e1 = !busy && req_valid1 && (!req_valid0 || !model_last);
        chk1("req_ready0", req_ready0, e0);
        chk1("req_ready1", req_ready1, e1);
        in_resp = busy && (cyc >= hs_cyc + (exp_err ? 1 : 2));
        chk1("rsp_valid0", rsp_valid0, in_resp && !cur_n);
        chk1("rsp_valid1", rsp_valid1, in_resp && cur_n);
        if (in_resp) begin
          chk32("rsp_result", rsp_result, exp_res);
          chk1("rsp_zero", rsp_zero, exp_zero);
          chk1("rsp_err", rsp_err, exp_err);
        end
        if (busy && !exp_err && cyc == hs_cyc + 1) begin
          chk32("exec_alu_a", alu_a, exp_a);
          chk32("exec_alu_b", alu_b, exp_b);
          chk32("exec_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
        end
        if (in_resp && (cur_n ? rsp_ready1 : rsp_ready0)) begin
          busy = 1'b0;
          model_last = cur_n;
          done_q.push_back({cur_n, exp_res, exp_zero, exp_err});
        end else if (e0 || e1) begin
          busy     = 1'b1;
          cur_n    = e1;
          hs_cyc   = cyc;
          exp_a    = e1 ? req_a1 : req_a0;
          exp_b    = e1 ? req_b1 : req_b0;
          exp_ctrl = e1 ? req_ctrl1 : req_ctrl0;
          exp_err  = !legal(exp_ctrl);
          exp_res  = exp_err ? 32'd0 : ref_alu(exp_a, exp_b, exp_ctrl);
          exp_zero = !exp_err && (exp_res == 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int cnt0;
    rst_n = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_a0 = '0; req_b0 = '0; req_ctrl0 = '0;
    req_a1 = '0; req_b1 = '0; req_ctrl1 = '0;
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;

    // Single add from requester 0 with exact latency.
    add_op(1'b0, 32'd5, 32'd7, 3'd0);
    do_reset();
    chk1("t1_ready0_cycle0", req_ready0, 1'b1);
    @(posedge clk); #1;
    chk1("t1_no_rsp_in_exec", rsp_valid0, 1'b0);
    @(posedge clk); #1;
    chk1("t1_rsp_valid0", rsp_valid0, 1'b1);
    chk32("t1_result", rsp_result, 32'd12);
    chk1("t1_zero", rsp_zero, 1'b0);
    chk1("t1_err", rsp_err, 1'b0);
    chk1("t1_rsp_valid1", rsp_valid1, 1'b0);
    drain("t1", 100);

    // Both valid from reset: alternating grants.
    add_op(1'b0, 32'd9, 32'd9, 3'd1);
    add_op(1'b0, 32'd9, 32'd9, 3'd1);
    add_op(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5);
    add_op(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd5);
    done_q.delete();
    do_reset();
    drain("t2", 200);
    chk32("t2_count", done_q.size(), 32'd4);
    chk_rec("t2_op0", 0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk_rec("t2_op1", 1, 1'b1, 32'd1, 1'b0, 1'b0);
    chk_rec("t2_op2", 2, 1'b0, 32'd0, 1'b1, 1'b0);
    chk_rec("t2_op3", 3, 1'b1, 32'd1, 1'b0, 1'b0);

    // Illegal opcode from requester 1.
    done_q.delete();
    add_op(1'b1, 32'h1234, 32'h5678, 3'd6);
    drain("t3", 100);
    chk_rec("t3_illegal", 0, 1'b1, 32'd0, 1'b0, 1'b1);

    // Response backpressure on requester 0 while requester 1 waits.
    done_q.delete();
    rdy_mode = 2;
    add_op(1'b0, 32'd100, 32'd23, 3'd1);
    add_op(1'b1, 32'd2, 32'd3, 3'd0);
    drain("t4", 200);
    chk_rec("t4_first", 0, 1'b0, 32'd77, 1'b0, 1'b0);
    chk_rec("t4_second", 1, 1'b1, 32'd5, 1'b0, 1'b0);
    rdy_mode = 0;

    // Reset in the middle of EXEC; last grant returns to 1.
    add_op(1'b0, 32'd1, 32'd1, 3'd0);
    drain("t5_pre", 100);
    add_op(1'b0, 32'd3, 32'd4, 3'd3);
    cnt0 = 0;
    do begin
      @(negedge clk); #1;
      cnt0++;
    end while (!hs0 && cnt0 < 50);
    chk1("t5_handshake_seen", hs0, 1'b1);
    @(posedge clk); #1;
    chk32("t5_exec_alu_a", alu_a, 32'd3);
    chk32("t5_exec_alu_ctrl", {29'd0, alu_ctrl}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk32("t5_rst_alu_a", alu_a, 32'd0);
    chk32("t5_rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk1("t5_no_stale_rsp", rsp_valid0, 1'b0);
    done_q.delete();
    add_op(1'b0, 32'd10, 32'd20, 3'd0);
    add_op(1'b1, 32'd30, 32'd40, 3'd0);
    drain("t5", 100);
    chk_rec("t5_tie_first", 0, 1'b0, 32'd30, 1'b0, 1'b0);
    chk_rec("t5_tie_second", 1, 1'b1, 32'd70, 1'b0, 1'b0);

    // Bitwise operations.
    done_q.delete();
    add_op(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2);
    add_op(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd3);
    drain("t6", 100);
    chk_rec("t6_and", 0, 1'b0, 32'h00F0_00F0, 1'b0, 1'b0);
    chk_rec("t6_or", 1, 1'b0, 32'hFFF0_FFF0, 1'b0, 1'b0);

    // Randomized traffic with random gaps and response backpressure.
    done_q.delete();
    rdy_mode = 1;
    gaps = 1;
    for (int i = 0; i < 150; i++) begin
      add_op(1'b0, rnd(), rnd(), 3'($urandom_range(0, 7)));
      add_op(1'b1, rnd(), rnd(), 3'($urandom_range(0, 7)));
    end
    drain("t7", 10000);
    chk32("t7_count", done_q.size(), 32'd300);
    cnt0 = 0;
    foreach (done_q[i]) if (!done_q[i].n) cnt0++;
    chk32("t7_count_req0", cnt0, 32'd150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the single-cycle 32-bit integer ALU between two requesters, for example the fetch-side address adder and the execute-stage datapath in the multicycle core. Each requester issues an operation over a valid/ready request channel and receives its result over its own valid/ready response channel. Grants are round-robin. Operands are registered before they drive the ALU, and the ALU result is registered before it is returned.

## Interface
- WIDTH, 32, operand and result width; matches the ALU data width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid0 / req_valid1  input  1  requester N presents an operation.
- req_ready0 / req_ready1  output  1  arbiter accepts requester N's operation this cycle.
- req_a0, req_b0 / req_a1, req_b1  input  WIDTH  operands.
- req_ctrl0 / req_ctrl1  input  3  ALU opcode:
  - 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than.
  - All other codes are illegal.
- rsp_valid0 / rsp_valid1  output  1  response for requester N is held on the shared response bus.
- rsp_ready0 / rsp_ready1  input  1  requester N consumes the response.
- rsp_result  output  WIDTH  registered ALU result; valid only while a rsp_validN is high.
- rsp_zero  output  1  registered ALU zero flag.
- rsp_err  output  1  operation used an illegal opcode.
- alu_a, alu_b  output  WIDTH  registered operands to the ALU.
- alu_ctrl  output  3  registered opcode to the ALU.
- alu_result  input  WIDTH  combinational ALU result.
- alu_zero  input  1  combinational ALU zero flag.

## Operation
- State machine: IDLE, EXEC, RESP.
  - Only one operation is in flight at a time.
- IDLE:
  - req_readyN = (state==IDLE) && (grant==N). This is combinational from state, the req_valids and last_grant.
  - Grant when both requesters are valid: the requester that is not last_grant.
  - Grant when one requester is valid: that requester.
  - req_valid must not depend on req_ready. A requester holds valid, operands and ctrl stable until its handshake.
  - On the req_validN && req_readyN edge, the arbiter latches:
    - req_aN → op_a, req_bN → op_b, req_ctrlN → op_ctrl;
    - N → gnt;
    - illegal-opcode check → op_err.
  - Next state after the handshake edge:
    - legal opcode → EXEC;
    - illegal opcode → RESP, with rsp_result=0, rsp_zero=0, rsp_err=1. The ALU is never driven with an illegal opcode.
- EXEC (exactly 1 cycle):
  - alu_a, alu_b and alu_ctrl hold op_a, op_b and op_ctrl.
  - At the end of the cycle: alu_result → rsp_result, alu_zero → rsp_zero, rsp_err=0, next state RESP.
- RESP:
  - rsp_valid[gnt]=1; the other rsp_valid stays 0.
  - rsp_result, rsp_zero and rsp_err are held stable until the handshake.
  - On the rsp_valid[gnt] && rsp_ready[gnt] edge: last_grant ← gnt, next state IDLE.
  - rsp_ready of the non-granted requester is ignored.
- alu_a, alu_b and alu_ctrl hold their last value outside EXEC. Only the EXEC cycle is meaningful.
- Width rule: no widening or truncation. Results are WIDTH bits exactly as the ALU returns them.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, alu_a, alu_b and alu_ctrl = 0.
- Legal-op latency:
  - Request handshake at edge T.
  - EXEC occupies cycle T..T+1.
  - rsp_valid rises after edge T+1.
- Illegal-op latency: rsp_valid rises after edge T (handshake edge).
- Throughput:
  - Best case, with rsp_ready held high: one legal operation every 3 cycles, one illegal operation every 2.
  - Next req_ready is no earlier than the cycle after the response handshake edge.
- Response backpressure: RESP is held indefinitely while rsp_ready is low. No new request is accepted.
- Simultaneous events:
  - Both requesters valid in the same IDLE cycle: exactly one req_ready is high.
  - Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…
- A requester dropping req_valid before its handshake is a protocol violation. The arbiter only requires that it never accepts an operation without a same-edge handshake.
- Reset mid-operation, in EXEC or RESP:
  - Pending operation discarded; no response is produced.
  - All outputs return to their reset values immediately.
  - last_grant=1.

## Test plan
- Reset, then requester 0 sends a=5, b=7, ctrl=000, with rsp_ready0=1 → req_ready0 in cycle 0; rsp_valid0 after 2 edges; rsp_result=12, rsp_zero=0, rsp_err=0; rsp_valid1 stays 0.
- Both requesters valid from reset:
  - requester 0: a=9, b=9, ctrl=001;
  - requester 1: a=0xFFFFFFFF, b=1, ctrl=101.
  - Required: requester 0 served first (result 0, zero=1); then requester 1 (result 1, zero=0); grant order 0,1,0,1 over four back-to-back operations.
- Requester 1 sends ctrl=110 → no EXEC cycle; rsp_valid1 one edge after the handshake; rsp_err=1, rsp_result=0, rsp_zero=0.
- Backpressure: rsp_ready0 held low for 5 cycles after rsp_valid0 rises, while requester 1 is valid.
  - Required: rsp_result stable, req_ready1=0 throughout.
  - After the response handshake, requester 1 is granted in the next IDLE cycle.
- Reset mid-EXEC: assert rst_n=0 during EXEC of a=3, b=4, ctrl=011 → outputs immediately 0; after release no rsp_valid appears; the next request from requester 1 tied with requester 0 goes to requester 0.
- Bitwise check, with rsp_ready held high:
  - a=0xF0F0F0F0, b=0x0FF00FF0, ctrl=010 → 0x00F000F0.
  - Same operands, ctrl=011 → 0xFFF0FFF0.
  - Required: alu_ctrl equals the issued ctrl during EXEC.
